// File: rtl/stage_1_pipelined_if.sv
// stage_1_pipelined_if: valid/ready bus of stage_1_pipelined.
// Carries frequency inputs and registered stage B results.
interface stage_1_pipelined_if #(
  parameter int DATA_16        = 16,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_DATA_WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_16-1:0]        FL;
  logic [DATA_16-1:0]        FH;
  logic [SYMBOL_WIDTH-1:0]   SYMBOL;
  logic [SYMBOL_WIDTH:0]     NSYMS;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_16-1:0]        UU;
  logic [DATA_16-1:0]        VV;
  logic                      COMP_mux_1;
  logic [LUT_DATA_WIDTH-1:0] lut_u_out;
  logic [LUT_DATA_WIDTH-1:0] lut_v_out;
  logic                      err_out;
  logic [31:0]               xfer_count;

  modport master (
    output in_valid, FL, FH, SYMBOL, NSYMS,
    output out_ready,
    input  in_ready, out_valid, UU, VV,
    input  COMP_mux_1, lut_u_out, lut_v_out,
    input  err_out, xfer_count
  );

  modport slave (
    input  in_valid, FL, FH, SYMBOL, NSYMS,
    input  out_ready,
    output in_ready, out_valid, UU, VV,
    output COMP_mux_1, lut_u_out, lut_v_out,
    output err_out, xfer_count
  );
endinterface

// File: rtl/stage_1_pipelined.sv
// stage_1_pipelined: 2-edge valid/ready stage, prob shift + LUT read.
// Optional symbol check enabled by STAGE_1_SYMBOL_CHECK_EN.
module stage_1_lut #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter bit KIND_V = 1'b0
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] q_o
);
  logic [31:0]   a;
  logic [DW-1:0] rom_d;
  logic [DW-1:0] q_q;

  // ROM contents as a closed-form function of the address
  always_comb begin
    a = 32'(addr_i);
    if (KIND_V) rom_d = DW'(a * 32'd40503);
    else        rom_d = DW'(a * a + 32'd1);
  end

  // registered read port; no reset so contents ignore reset_n
  always_ff @(posedge clk_i) begin
    q_q <= rom_d;
  end

  assign q_o = q_q;
endmodule

module stage_1_pipelined #(
  parameter int DATA_16        = 16,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_ADDR_WIDTH = 2*SYMBOL_WIDTH,
  parameter int LUT_DATA_WIDTH = 16,
  parameter int PROB_SHIFT     = 6
) (
  input logic                clk_stage_1,
  input logic                reset_n,
  stage_1_pipelined_if.slave bus
);
  localparam int SW = SYMBOL_WIDTH;

  logic                      advance;
  logic                      valid_a_q, valid_a_d;
  logic [DATA_16-1:0]        fl_a_q, fl_a_d;
  logic [DATA_16-1:0]        fh_a_q, fh_a_d;
  logic [SW-1:0]             sym_a_q, sym_a_d;
  logic [SW:0]               ns_a_q, ns_a_d;
  logic [LUT_ADDR_WIDTH-1:0] lut_addr;
  logic [LUT_DATA_WIDTH-1:0] lut_u_rd, lut_v_rd;

  logic                      out_valid_q;
  logic [DATA_16-1:0]        uu_q, vv_q;
  logic                      comp_q;
  logic [LUT_DATA_WIDTH-1:0] lut_u_out_q, lut_v_out_q;
  logic [31:0]               xfer_q;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // stage A next state: load inputs on advance, else hold
  always_comb begin
    valid_a_d = valid_a_q;
    fl_a_d    = fl_a_q;
    fh_a_d    = fh_a_q;
    sym_a_d   = sym_a_q;
    ns_a_d    = ns_a_q;
    if (advance) begin
      valid_a_d = bus.in_valid;
      fl_a_d    = bus.FL;
      fh_a_d    = bus.FH;
      sym_a_d   = bus.SYMBOL;
      ns_a_d    = bus.NSYMS;
    end
  end

  // address tracks stage A next state so LUT q matches stage A
  assign lut_addr = LUT_ADDR_WIDTH'({
    SW'(ns_a_d - (SW+1)'(1)), sym_a_d});

  // stage A register bank
  always_ff @(posedge clk_stage_1 or negedge reset_n) begin
    if (!reset_n) begin
      valid_a_q <= 1'b0;
      fl_a_q    <= '0;
      fh_a_q    <= '0;
      sym_a_q   <= '0;
      ns_a_q    <= '0;
    end else begin
      valid_a_q <= valid_a_d;
      fl_a_q    <= fl_a_d;
      fh_a_q    <= fh_a_d;
      sym_a_q   <= sym_a_d;
      ns_a_q    <= ns_a_d;
    end
  end

  stage_1_lut #(
    .AW    (LUT_ADDR_WIDTH),
    .DW    (LUT_DATA_WIDTH),
    .KIND_V(1'b0)
  ) lut_u (
    .clk_i (clk_stage_1),
    .addr_i(lut_addr),
    .q_o   (lut_u_rd)
  );

  stage_1_lut #(
    .AW    (LUT_ADDR_WIDTH),
    .DW    (LUT_DATA_WIDTH),
    .KIND_V(1'b1)
  ) lut_v (
    .clk_i (clk_stage_1),
    .addr_i(lut_addr),
    .q_o   (lut_v_rd)
  );

  // stage B: capture results on advance, hold under stall
  always_ff @(posedge clk_stage_1 or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      uu_q        <= '0;
      vv_q        <= '0;
      comp_q      <= 1'b0;
      lut_u_out_q <= '0;
      lut_v_out_q <= '0;
    end else if (advance) begin
      out_valid_q <= valid_a_q;
      uu_q        <= fl_a_q >> PROB_SHIFT;
      vv_q        <= fh_a_q >> PROB_SHIFT;
      comp_q      <= !fl_a_q[DATA_16-1];
      lut_u_out_q <= lut_u_rd;
      lut_v_out_q <= lut_v_rd;
    end
  end

  // completed output transfers, wraps naturally
  always_ff @(posedge clk_stage_1 or negedge reset_n) begin
    if (!reset_n) begin
      xfer_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      xfer_q <= xfer_q + 32'd1;
    end
  end

`ifdef STAGE_1_SYMBOL_CHECK_EN
  localparam logic [SW:0] NS_MAX = (SW+1)'(1) << SW;
  logic err_a;
  logic err_q;

  // flag symbols outside the declared alphabet
  always_comb begin
    err_a = (ns_a_q == '0) || (ns_a_q > NS_MAX) ||
            ({1'b0, sym_a_q} >= ns_a_q);
  end

  // error flag travels with its data into stage B
  always_ff @(posedge clk_stage_1 or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (advance) begin
      err_q <= err_a;
    end
  end

  assign bus.err_out = err_q;
`else
  assign bus.err_out = 1'b0;
`endif

  assign bus.out_valid  = out_valid_q;
  assign bus.UU         = uu_q;
  assign bus.VV         = vv_q;
  assign bus.COMP_mux_1 = comp_q;
  assign bus.lut_u_out  = lut_u_out_q;
  assign bus.lut_v_out  = lut_v_out_q;
  assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_stage_1_pipelined.sv
// tb_stage_1_pipelined: vectors, corner sequences, random vs model.
// Honors STAGE_1_SYMBOL_CHECK_EN for the expected err_out.
module tb_stage_1_pipelined;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  stage_1_pipelined_if #(
    .DATA_16(16), .SYMBOL_WIDTH(4), .LUT_DATA_WIDTH(16)
  ) bus ();

  stage_1_pipelined dut (
    .clk_stage_1(clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [15:0] uu, vv;
    logic        comp;
    logic [15:0] lu, lv;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] fl, fh;
    logic [3:0]  sym;
    logic [4:0]  ns;
    logic [15:0] uu, vv;
    logic        comp;
    logic [7:0]  addr;
    logic        err;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  exp_t sbq[$];
  vec_t tbl[8];

  function automatic logic [15:0] lut_u_ref(input int a);
    return 16'((a * a + 1) % 65536);
  endfunction

  function automatic logic [15:0] lut_v_ref(input int a);
    return 16'((a * 40503) % 65536);
  endfunction

  function automatic exp_t model(input int fl, input int fh,
                                 input int sym, input int ns);
    exp_t e;
    int   a;
    a      = ((ns + 15) % 16) * 16 + sym;
    e.uu   = 16'(fl / 64);
    e.vv   = 16'(fh / 64);
    e.comp = (fl < 32768);
    e.lu   = lut_u_ref(a);
    e.lv   = lut_v_ref(a);
`ifdef STAGE_1_SYMBOL_CHECK_EN
    e.err  = (ns == 0) || (ns > 16) || (sym >= ns);
`else
    e.err  = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input exp_t e);
    chk("sb_uu",   bus.UU,         e.uu);
    chk("sb_vv",   bus.VV,         e.vv);
    chk("sb_comp", bus.COMP_mux_1, e.comp);
    chk("sb_lu",   bus.lut_u_out,  e.lu);
    chk("sb_lv",   bus.lut_v_out,  e.lv);
    chk("sb_err",  bus.err_out,    e.err);
  endtask

  task automatic drive(input logic [15:0] fl, input logic [15:0] fh,
                       input logic [3:0] sym, input logic [4:0] ns);
    bus.FL     = fl;
    bus.FH     = fh;
    bus.SYMBOL = sym;
    bus.NSYMS  = ns;
  endtask

  // one clock: sample/score at negedge, return 1 unit after posedge
  task automatic cycle();
    exp_t e;
    bit   ox, ix;
    @(negedge clk);
    ox = bus.out_valid && bus.out_ready;
    ix = bus.in_valid && bus.in_ready;
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out: got out_valid=1 want 0 @%0t",
                 $time);
      end else begin
        cmp_out(sbq[0]);
        if (ox) void'(sbq.pop_front());
      end
    end
    if (ox) exp_cnt++;
    if (ix) begin
      e = model(int'(bus.FL), int'(bus.FH),
                int'(bus.SYMBOL), int'(bus.NSYMS));
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("xfer_count", bus.xfer_count, exp_cnt);
  endtask

  initial begin
    int   start;
    logic exp_err;

    tbl[0] = '{16'h8000, 16'h4000, 4'd2, 5'd4,
               16'h0200, 16'h0100, 1'b0, 8'h32, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0000, 4'd0, 5'd1,
               16'h01FF, 16'h0000, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 4'd15, 5'd16,
               16'h03FF, 16'h03FF, 1'b0, 8'hFF, 1'b0};
    tbl[3] = '{16'h0000, 16'h0040, 4'd5, 5'd4,
               16'h0000, 16'h0001, 1'b1, 8'h35, 1'b1};
    tbl[4] = '{16'h1234, 16'hABCD, 4'd3, 5'd0,
               16'h0048, 16'h02AF, 1'b1, 8'hF3, 1'b1};
    tbl[5] = '{16'h8001, 16'h7FC0, 4'd3, 5'd4,
               16'h0200, 16'h01FF, 1'b0, 8'h33, 1'b0};
    tbl[6] = '{16'h0040, 16'h0000, 4'd0, 5'd17,
               16'h0001, 16'h0000, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{16'h003F, 16'hFFC0, 4'd7, 5'd31,
               16'h0000, 16'h03FF, 1'b1, 8'hE7, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(16'h0, 16'h0, 4'd0, 5'd0);

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid,  0);
    chk("rst_uu",        bus.UU,         0);
    chk("rst_vv",        bus.VV,         0);
    chk("rst_comp",      bus.COMP_mux_1, 0);
    chk("rst_lu",        bus.lut_u_out,  0);
    chk("rst_lv",        bus.lut_v_out,  0);
    chk("rst_err",       bus.err_out,    0);
    chk("rst_count",     bus.xfer_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);

    // table vectors, isolated, with latency check
    foreach (tbl[i]) begin
`ifdef STAGE_1_SYMBOL_CHECK_EN
      exp_err = tbl[i].err;
`else
      exp_err = 1'b0;
`endif
      drive(tbl[i].fl, tbl[i].fh, tbl[i].sym, tbl[i].ns);
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      chk("tbl_edge1_valid", bus.out_valid, 0);
      cycle();
      chk("tbl_edge2_valid", bus.out_valid, 1);
      chk("tbl_uu",   bus.UU,         tbl[i].uu);
      chk("tbl_vv",   bus.VV,         tbl[i].vv);
      chk("tbl_comp", bus.COMP_mux_1, tbl[i].comp);
      chk("tbl_lu",   bus.lut_u_out,  lut_u_ref(int'(tbl[i].addr)));
      chk("tbl_lv",   bus.lut_v_out,  lut_v_ref(int'(tbl[i].addr)));
      chk("tbl_err",  bus.err_out,    exp_err);
      cycle();
    end

    // back-to-back stream of 8
    start = exp_cnt;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        drive(16'((k - 1) * 16'h1000), 16'(k * 16'h0100),
              4'(k), 5'd9);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      cycle();
      chk("b2b_valid", bus.out_valid, (k >= 2 && k <= 9));
    end
    chk("b2b_count", bus.xfer_count, start + 8);

    // backpressure with two transfers in flight
    bus.out_ready = 1'b0;
    drive(16'h1111, 16'h2222, 4'd1, 5'd3);
    bus.in_valid = 1'b1;
    cycle();
    drive(16'h3333, 16'h4444, 4'd2, 5'd3);
    cycle();
    drive(16'h5555, 16'h6666, 4'd0, 5'd2);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_in_ready",  bus.in_ready,  0);
      chk("bp_out_valid", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("bp_drained", sbq.size(), 0);

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      drive(16'($urandom), 16'($urandom),
            4'($urandom), 5'($urandom));
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid,  0);
    chk("mrst_uu",        bus.UU,         0);
    chk("mrst_vv",        bus.VV,         0);
    chk("mrst_comp",      bus.COMP_mux_1, 0);
    chk("mrst_lu",        bus.lut_u_out,  0);
    chk("mrst_lv",        bus.lut_v_out,  0);
    chk("mrst_err",       bus.err_out,    0);
    chk("mrst_count",     bus.xfer_count, 0);
    sbq.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mrst_in_ready", bus.in_ready, 1);
    drive(tbl[0].fl, tbl[0].fh, tbl[0].sym, tbl[0].ns);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("mrst_edge1_valid", bus.out_valid, 0);
    cycle();
    chk("mrst_edge2_valid", bus.out_valid, 1);
    chk("mrst_uu_out",      bus.UU,        16'h0200);
    cycle();

    // random traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      drive(16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    chk("rand_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
